// File: rtl/chrono_pkg.sv
// Shared encodings for the stopwatch sequencer: FSM states, command bit
// positions and Avalon-MM register addresses.
package chrono_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
    } state_e;

    localparam int unsigned CmdRun   = 0;
    localparam int unsigned CmdClear = 1;
    localparam int unsigned CmdLap   = 2;

    localparam logic [1:0] AddrTime   = 2'd0;
    localparam logic [1:0] AddrLap    = 2'd1;
    localparam logic [1:0] AddrStatus = 2'd2;

endpackage

// File: rtl/chrono_bcd_digit.sv
// Two-digit BCD counter that wraps at MAX (99 or 59). It raises carry in the
// cycle where an increment wraps it.
module chrono_bcd_digit #(
    parameter int unsigned MAX = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    localparam logic [7:0] MaxBcd = {4'(MAX / 10), 4'(MAX % 10)};

    logic [7:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            if (value_q == MaxBcd) begin
                value_d = 8'h00;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MaxBcd);

endmodule

// File: rtl/chrono_controller.sv
// Stopwatch sequencer: run/pause/clear FSM driven by PIO command edges, a
// hundredths prescaler, a BCD mm:ss.cc counter with lap capture and a read slave.
module chrono_controller import chrono_pkg::*; #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cmd,
    input  logic [1:0]  address,
    input  logic        chipselect,
    output logic [31:0] readdata,
    output logic [23:0] time_bcd,
    output logic        running,
    output logic        tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("chrono_controller: CLK_HZ / TICK_HZ must be at least 2");
    end

    state_e       state_q, state_d;
    logic [2:0]   cmd_q;
    logic [PW-1:0] presc_q, presc_d;
    logic         tick_q, tick_d;
    logic         running_q, running_d;
    logic [23:0]  lap_q, lap_d;
    logic         ovf_q, ovf_d;

    logic [2:0]   rise, fall;
    logic         clr;
    logic         cc_carry, ss_carry, mm_carry;
    logic [7:0]   cc_val, ss_val, mm_val;
    logic         unused_cmd;

    assign unused_cmd = ^cmd[7:3];
    assign rise = cmd[2:0] & ~cmd_q;
    assign fall = ~cmd[2:0] & cmd_q;
    // CLEAR has no effect in IDLE, where time and lap are already zero.
    assign clr  = rise[CmdClear] && (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (rise[CmdRun]) state_d = StRunning;
            StRunning: if (fall[CmdRun]) state_d = StPaused;
            StPaused: begin
                if (rise[CmdRun]) begin
                    state_d = StRunning;
                end else if (rise[CmdClear]) begin
                    state_d = StIdle;
                end
            end
            default:   state_d = StIdle;
        endcase

        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clr || (state_q == StIdle && rise[CmdRun])) begin
            presc_d = '0;
        end else if (state_q == StRunning) begin
            if (presc_q == PrescLast) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        lap_d = lap_q;
        if (clr) begin
            lap_d = 24'h0;
        end else if (rise[CmdLap] && state_q != StIdle) begin
            lap_d = time_bcd;
        end

        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (mm_carry) begin
            ovf_d = 1'b1;
        end

        running_d = (state_d == StRunning);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= 3'b000;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            lap_q     <= 24'h0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd[2:0];
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
        end
    end

    // Time advances on the edge that ends the registered tick cycle.
    chrono_bcd_digit #(.MAX(99)) u_cc (
        .clk   (clk),
        .reset (reset),
        .inc   (tick_q),
        .clr   (clr),
        .value (cc_val),
        .carry (cc_carry)
    );

    chrono_bcd_digit #(.MAX(59)) u_ss (
        .clk   (clk),
        .reset (reset),
        .inc   (cc_carry),
        .clr   (clr),
        .value (ss_val),
        .carry (ss_carry)
    );

    chrono_bcd_digit #(.MAX(59)) u_mm (
        .clk   (clk),
        .reset (reset),
        .inc   (ss_carry),
        .clr   (clr),
        .value (mm_val),
        .carry (mm_carry)
    );

    assign time_bcd = {mm_val, ss_val, cc_val};
    assign running  = running_q;
    assign tick     = tick_q;

    always_comb begin
        readdata = 32'h0;
        if (chipselect) begin
            case (address)
                AddrTime:   readdata = {8'h0, time_bcd};
                AddrLap:    readdata = {8'h0, lap_q};
                AddrStatus: readdata = {29'b0, ovf_q, state_q};
                default:    readdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_chrono_controller.sv
// Scoreboard bench for chrono_controller: stimulus pushes expected outputs from
// an integer-time reference model, a negedge monitor pops and compares.
module tb_chrono_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cmd;
    logic [1:0]  address;
    logic        chipselect;
    logic [31:0] readdata;
    logic [23:0] time_bcd;
    logic        running;
    logic        tick;

    always #5 clk = ~clk;

    chrono_controller #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .address    (address),
        .chipselect (chipselect),
        .readdata   (readdata),
        .time_bcd   (time_bcd),
        .running    (running),
        .tick       (tick)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        run;
        logic        tk;
        logic [23:0] tm;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: time kept as an integer count of hundredths.
    localparam int Div     = 10;
    localparam int MaxTime = 60 * 60 * 100 - 1;
    int         m_st   = 0;
    int         m_frac = 0;
    int         m_h    = 0;
    int         m_lap  = 0;
    bit         m_ovf  = 0;
    bit         m_tick = 0;
    logic [2:0] m_prev = 3'b000;

    function automatic logic [23:0] to_bcd(input int h);
        int mm, ss, cc;
        mm = h / 6000;
        ss = (h / 100) % 60;
        cc = h % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h0, to_bcd(m_h)};
            2'd1:    return {8'h0, to_bcd(m_lap)};
            2'd2:    return {29'b0, m_ovf, 2'(m_st)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] r, f;
        bit         c;
        int         old_h;
        if (reset) begin
            m_st = 0; m_frac = 0; m_h = 0; m_lap = 0; m_ovf = 0; m_tick = 0;
            m_prev = 3'b000;
            return;
        end
        r = cmd[2:0] & ~m_prev;
        f = ~cmd[2:0] & m_prev;
        c = r[1] && (m_st != 0);
        old_h = m_h;
        if (c) begin
            m_h = 0;
            m_ovf = 0;
        end else if (m_tick) begin
            if (m_h == MaxTime) begin
                m_h = 0;
                m_ovf = 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        if (c) m_lap = 0;
        else if (r[2] && m_st != 0) m_lap = old_h;
        m_tick = 0;
        if (c || (m_st == 0 && r[0])) begin
            m_frac = 0;
        end else if (m_st == 1) begin
            m_frac = m_frac + 1;
            if (m_frac == Div) begin
                m_frac = 0;
                m_tick = 1;
            end
        end
        case (m_st)
            0: if (r[0]) m_st = 1;
            1: if (f[0]) m_st = 2;
            default: begin
                if (r[0]) m_st = 1;
                else if (r[1]) m_st = 0;
            end
        endcase
        m_prev = cmd[2:0];
    endtask

    task automatic step(input logic [7:0] c, input bit cs, input logic [1:0] a);
        exp_t e;
        cmd = c;
        chipselect = cs;
        address = a;
        e.addr = a;
        e.rd   = cs ? exp_rd(a) : 32'h0;
        e.run  = (m_st == 1);
        e.tk   = m_tick;
        e.tm   = to_bcd(m_h);
        exp_q.push_back(e);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            step(c, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end
    endtask

    // Jumps the counter to 59:59.99 while paused so the wrap can be reached quickly.
    task automatic preload();
        force dut.u_mm.value_q = 8'h59;
        force dut.u_ss.value_q = 8'h59;
        force dut.u_cc.value_q = 8'h99;
        m_h = MaxTime;
        step(cmd, 1'b1, 2'd0);
        release dut.u_mm.value_q;
        release dut.u_ss.value_q;
        release dut.u_cc.value_q;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("running", {31'b0, running}, {31'b0, e.run});
                check("tick", {31'b0, tick}, {31'b0, e.tk});
                check("time_bcd", {8'h0, time_bcd}, {8'h0, e.tm});
                check($sformatf("readdata[%0d]", e.addr), readdata, e.rd);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rc;
        reset = 1'b1;
        cmd = 8'h00;
        chipselect = 1'b0;
        address = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and read map
        for (int a = 0; a < 4; a++) step(8'h00, 1'b1, 2'(a));
        step(8'h00, 1'b0, 2'd2);

        // Free run from IDLE
        run(8'h01, 1000);
        run(8'h00, 5);
        step(8'h02, 1'b1, 2'd2);
        run(8'h00, 3);

        // Pause and resume keeps the fractional count
        run(8'h01, 373);
        run(8'h00, 50);
        step(8'h00, 1'b1, 2'd2);
        run(8'h01, 100);
        run(8'h00, 3);
        step(8'h02, 1'b1, 2'd0);
        run(8'h00, 2);

        // Lap capture, then lap in IDLE
        run(8'h01, 155);
        step(8'h05, 1'b1, 2'd1);
        run(8'h05, 40);
        step(8'h05, 1'b1, 2'd1);
        run(8'h01, 5);
        run(8'h00, 4);
        step(8'h02, 1'b1, 2'd1);
        run(8'h00, 2);
        step(8'h04, 1'b1, 2'd1);
        run(8'h04, 3);
        run(8'h00, 2);

        // Wrap at 59:59.99 sets sticky overflow; CLEAR in RUNNING clears it
        run(8'h01, 23);
        run(8'h00, 5);
        preload();
        run(8'h00, 3);
        run(8'h01, 30);
        step(8'h01, 1'b1, 2'd2);
        step(8'h03, 1'b1, 2'd2);
        step(8'h03, 1'b1, 2'd2);
        run(8'h03, 20);

        // CLEAR and LAP together while RUNNING, then reset mid-count
        run(8'h01, 57);
        step(8'h07, 1'b1, 2'd1);
        step(8'h07, 1'b1, 2'd0);
        run(8'h07, 15);
        run(8'h01, 23);
        reset = 1'b1;
        step(8'h01, 1'b1, 2'd0);
        reset = 1'b0;
        for (int a = 0; a < 3; a++) step(8'h00, 1'b1, 2'(a));

        // Randomized command sequences with occasional resets
        for (int i = 0; i < 300; i++) begin
            rc = 8'($urandom);
            if ($urandom_range(0, 99) < 2) reset = 1'b1;
            step(rc, 1'b1, 2'($urandom_range(0, 3)));
            reset = 1'b0;
            run(rc, $urandom_range(0, 24));
        end

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chrono_controller.md
# chrono_controller

Stopwatch sequencer for the multimode watch. It consumes the 8-bit command word driven by the Nios-controlled chronometer PIO and runs a run/pause/clear state machine. It also runs a 10 ms time base and a BCD mm:ss.cc counter with lap capture. Results go to the display mux and back to the CPU through a small Avalon-MM read slave.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, count rate (hundredths). DIV = CLK_HZ/TICK_HZ; DIV ≥ 2 is required and is checked at elaboration.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- cmd  in  8  chronometer PIO word.
  - bit0 RUN: level-sensitive; its rising edge starts, its falling edge pauses.
  - bit1 CLEAR: acts on its rising edge.
  - bit2 LAP: acts on its rising edge.
  - bits 7:3 are ignored.
- address  in  2  Avalon-MM slave word address.
- chipselect  in  1  Avalon-MM select.
- readdata  out  32  Avalon-MM read data, zero wait states.
- time_bcd  out  24  live time {mm, ss, cc}, two BCD digits each.
- running  out  1  high in RUNNING.
- tick  out  1  one-cycle pulse on each counted hundredth.

## Operation
- Command edges are detected against cmd_q, a register holding the previous cmd: rise = cmd & ~cmd_q, fall = ~cmd & cmd_q. cmd_q resets to 0.
- States are IDLE, RUNNING and PAUSED. Transitions:
  - IDLE → RUNNING on RUN rise; the prescaler restarts from 0.
  - RUNNING → PAUSED on RUN fall.
  - PAUSED → RUNNING on RUN rise; the prescaler keeps its fractional count.
  - PAUSED → IDLE on CLEAR rise; time, lap and overflow are zeroed.
  - CLEAR rise in RUNNING zeroes time, lap, overflow and the prescaler, and the state stays RUNNING.
  - CLEAR rise in IDLE is a no-op.
- LAP rise in RUNNING or PAUSED copies time_bcd into lap_bcd. LAP rise in IDLE is ignored.
- Simultaneous edges in the same cycle:
  - CLEAR and LAP: CLEAR wins and lap_bcd becomes 0.
  - RUN rise and CLEAR in PAUSED: the block goes RUNNING with zeroed time.
  - A tick in the same cycle as CLEAR: CLEAR wins and the result is 0, not 1.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING.
  - At DIV-1, tick = 1 and the prescaler wraps to 0.
  - Width is $clog2(DIV).
- Time counter:
  - cc increments 00..99 in BCD; its carry feeds ss 00..59, whose carry feeds mm 00..59.
  - At 59:59.99 a tick produces 00:00.00 and sets sticky overflow; counting continues.
  - Overflow is cleared only by CLEAR or reset.
- Read map:
  - 0: {8'h0, time_bcd}.
  - 1: {8'h0, lap_bcd}.
  - 2: {29'b0, overflow, state[1:0]}.
  - 3: 0.
  - readdata is 0 when chipselect is low.
- Reset drives state to IDLE. time_bcd, lap_bcd, overflow, prescaler, cmd_q, running, tick and readdata all reset to 0. Reset overrides every command, including mid-count.

## Timing
- A cmd change takes effect on the next clk edge: running and the state change one cycle after cmd changes.
- Start latency: the first tick occurs DIV cycles after running rises, for a start from IDLE.
- time_bcd updates on the edge that ends the tick cycle and is registered. Lap capture and clear are visible one cycle after the edge.
- readdata is a combinational mux of registered values and is valid in the same cycle as address/chipselect.
- Commands must be held stable for ≥ 1 cycle; this holds for PIO writes. Repeated writes of the same value produce no edge.

## Structure
- Package chrono_pkg holds:
  - the state encoding: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2;
  - the cmd bit indices RUN=0, CLEAR=1, LAP=2;
  - the register addresses TIME=0, LAP=1, STATUS=2.
- Sub-module chrono_bcd_digit: two-digit BCD counter with parameter MAX (99 or 59), inputs inc and clr, outputs value[7:0] and carry. It is instantiated three times.
- Prescaler, FSM, lap register and read mux stay in chrono_controller.

## Test plan
All scenarios use CLK_HZ=1000 and TICK_HZ=100, so DIV=10.
1. Reset, then read addresses 0, 1 and 2 → all 0. running=0.
2. cmd=0x01 for 1000 cycles → running high one cycle later; first tick after 10 cycles; time_bcd=0x000100 (00:01.00) after 100 ticks.
3. Run 37 ticks, then cmd=0x00 for 50 cycles, then cmd=0x01 → time holds at 0x000037 while paused; STATUS=2; counting resumes with no lost fraction.
4. Run 15 ticks, then cmd=0x05 (lap rise) → addr1 = 0x000015 while addr0 keeps counting. Lap in IDLE leaves addr1 unchanged.
5. Preload by running to 0x595999, then one tick → time_bcd=0x000000; STATUS bit2=1. A CLEAR rise clears it.
6. CLEAR and LAP rising in the same cycle while RUNNING → time=0, lap=0, state stays RUNNING. Reset asserted mid-count → all outputs 0 in the next cycle.
